// File: rtl/spi_dac_wb_responder_pkg.sv
// spi_dac_wb_responder_pkg: register map, SPI FSM encoding and byte-lane helper shared with the bus master.
package spi_dac_wb_responder_pkg;
  typedef enum logic [1:0] {ST_IDLE = 2'd0, ST_SHIFT = 2'd1, ST_FINISHED = 2'd2} spi_state_e;
  // Word indices as decoded from wb_adr[4:2]; the byte offset is index*4.
  localparam logic [2:0] REG_READY = 3'd0;
  localparam logic [2:0] REG_ARM = 3'd1;
  localparam logic [2:0] REG_FINISHED = 3'd2;
  localparam logic [2:0] REG_TO_SLAVE = 3'd3;
  localparam logic [2:0] REG_WAIT = 3'd4;
  localparam logic [2:0] REG_FROM_SLAVE = 3'd5;
  function automatic logic [31:0] sel_merge(input logic [31:0] old_v, input logic [31:0] new_v,
                                            input logic [3:0] sel);
    logic [31:0] r;
    for (int i = 0; i < 4; i++) r[8*i +: 8] = sel[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
    return r;
  endfunction
endpackage

// File: rtl/spi_shift_engine.sv
// spi_shift_engine: mode-1 MSB-first SPI master that shifts one frame per arm and reports idle/finished.
module spi_shift_engine
  import spi_dac_wb_responder_pkg::*;
#(
  parameter int SPI_WID = 24,
  parameter int CLK_HALF = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               arm,
  input  logic [SPI_WID-1:0] to_slave,
  output logic [SPI_WID-1:0] from_slave,
  output logic               ready_to_arm,
  output logic               finished,
  output logic               sck,
  output logic               mosi,
  input  logic               miso,
  output logic               ss_l
);
  localparam int CW = $clog2(CLK_HALF + 1);
  localparam int BW = $clog2(SPI_WID + 1);
  spi_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [SPI_WID-1:0] sh_q, sh_d, from_q, from_d;
  logic sck_q, sck_d, mosi_q, mosi_d, ss_q, ss_d, tick;
  assign tick = cnt_q == CW'(CLK_HALF - 1);
  assign ready_to_arm = state_q == ST_IDLE;
  assign finished = state_q == ST_FINISHED;
  assign from_slave = from_q;
  assign sck = sck_q;
  assign mosi = mosi_q;
  assign ss_l = ss_q;
  // The shift register doubles as the receive register: miso enters at the LSB as the MSB leaves.
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    bit_d = bit_q;
    sh_d = sh_q;
    from_d = from_q;
    sck_d = sck_q;
    mosi_d = mosi_q;
    ss_d = ss_q;
    case (state_q)
      ST_IDLE: if (arm) begin
        state_d = ST_SHIFT;
        sh_d = to_slave;
        mosi_d = to_slave[SPI_WID-1];
        sck_d = 1'b1;
        ss_d = 1'b0;
        cnt_d = '0;
        bit_d = '0;
      end
      ST_SHIFT: begin
        cnt_d = tick ? '0 : cnt_q + 1'b1;
        if (tick && sck_q) begin
          sck_d = 1'b0;
          sh_d = {sh_q[SPI_WID-2:0], miso};
          bit_d = bit_q + 1'b1;
        end else if (tick && bit_q == BW'(SPI_WID)) begin
          state_d = arm ? ST_FINISHED : ST_IDLE;
          ss_d = 1'b1;
          mosi_d = 1'b0;
          from_d = sh_q;
        end else if (tick) begin
          sck_d = 1'b1;
          mosi_d = sh_q[SPI_WID-1];
        end
      end
      ST_FINISHED: if (!arm) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q <= '0;
      bit_q <= '0;
      sh_q <= '0;
      from_q <= '0;
      sck_q <= 1'b0;
      mosi_q <= 1'b0;
      ss_q <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q <= cnt_d;
      bit_q <= bit_d;
      sh_q <= sh_d;
      from_q <= from_d;
      sck_q <= sck_d;
      mosi_q <= mosi_d;
      ss_q <= ss_d;
    end
  end
endmodule

// File: rtl/spi_dac_wb_responder.sv
// spi_dac_wb_responder: Wishbone register front-end for an SPI DAC, with a stalling wait-for-done register.
module spi_dac_wb_responder
  import spi_dac_wb_responder_pkg::*;
#(
  parameter int SPI_WID = 24,
  parameter int CLK_HALF = 2,
  parameter int WAIT_TIMEOUT = 4095
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        wb_cyc,
  input  logic        wb_stb,
  input  logic        wb_we,
  input  logic [3:0]  wb_sel,
  input  logic [31:0] wb_adr,
  input  logic [31:0] wb_dat_w,
  output logic [31:0] wb_dat_r,
  output logic        wb_ack,
  output logic        sck,
  output logic        mosi,
  input  logic        miso,
  output logic        ss_l
);
  localparam int TW = $clog2(WAIT_TIMEOUT + 1);
  logic ack_q, ack_d, arm_q, arm_d, rdy, fin, req, unused_adr;
  logic [31:0] dat_q, dat_d, rd_data;
  logic [SPI_WID-1:0] ts_q, ts_d, from_slave;
  logic [TW-1:0] stall_q, stall_d;
  logic [2:0] idx;
  assign req = wb_cyc && wb_stb && !ack_q;
  assign idx = wb_adr[4:2];
  assign unused_adr = ^{wb_adr[31:5], wb_adr[1:0]};
  assign wb_ack = ack_q;
  assign wb_dat_r = dat_q;
  always_comb begin
    case (idx)
      REG_READY: rd_data = {31'b0, rdy};
      REG_ARM: rd_data = {31'b0, arm_q};
      REG_FINISHED: rd_data = {31'b0, fin};
      REG_TO_SLAVE: rd_data = 32'(ts_q);
      REG_FROM_SLAVE: rd_data = 32'(from_slave);
      default: rd_data = '0;
    endcase
  end
  // The engine sees arm_d so a same-cycle arm write steers the end-of-frame decision.
  always_comb begin
    ack_d = 1'b0;
    dat_d = '0;
    arm_d = arm_q;
    ts_d = ts_q;
    stall_d = '0;
    if (req && idx == REG_WAIT && !wb_we) begin
      if (rdy || fin) begin
        ack_d = 1'b1;
        dat_d = {30'b0, fin, rdy};
      end else if (stall_q == TW'(WAIT_TIMEOUT - 1)) ack_d = 1'b1;
      else stall_d = stall_q + 1'b1;
    end else if (req) begin
      ack_d = 1'b1;
      dat_d = rd_data;
      if (wb_we && idx == REG_ARM) arm_d = wb_sel[0] ? wb_dat_w[0] : arm_q;
      if (wb_we && idx == REG_TO_SLAVE) ts_d = SPI_WID'(sel_merge(32'(ts_q), wb_dat_w, wb_sel));
    end
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ack_q <= 1'b0;
      dat_q <= '0;
      arm_q <= 1'b0;
      ts_q <= '0;
      stall_q <= '0;
    end else begin
      ack_q <= ack_d;
      dat_q <= dat_d;
      arm_q <= arm_d;
      ts_q <= ts_d;
      stall_q <= stall_d;
    end
  end
  spi_shift_engine #(.SPI_WID(SPI_WID), .CLK_HALF(CLK_HALF)) u_engine (
    .clk(clk),
    .rst_n(rst_n),
    .arm(arm_d),
    .to_slave(ts_q),
    .from_slave(from_slave),
    .ready_to_arm(rdy),
    .finished(fin),
    .sck(sck),
    .mosi(mosi),
    .miso(miso),
    .ss_l(ss_l)
  );
endmodule

// File: tb/tb_spi_dac_wb_responder.sv
// tb_spi_dac_wb_responder: directed and randomized checks of the SPI DAC Wishbone responder against a register/frame model.
module tb_spi_dac_wb_responder;
  logic clk = 1'b0, rst_n = 1'b0;
  logic cyc = 1'b0, stb = 1'b0, we = 1'b0, use_b = 1'b0;
  logic [3:0] sel = '0;
  logic [31:0] adr = '0, dw = '0, dr_a, dr_b, dr_m;
  logic ack_a, ack_b, ack_m, sck_a, mosi_a, ss_a, sck_b, mosi_b, ss_b;
  logic miso_a = 1'b0;
  int checks = 0, errors = 0;
  logic [23:0] rx, pat, m_ts, m_from;
  logic m_arm, ss_glitch;
  int nb = 0, mi = 24;

  always #5 clk = ~clk;

  spi_dac_wb_responder dut_a (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc && !use_b), .wb_stb(stb), .wb_we(we), .wb_sel(sel),
    .wb_adr(adr), .wb_dat_w(dw), .wb_dat_r(dr_a), .wb_ack(ack_a),
    .sck(sck_a), .mosi(mosi_a), .miso(miso_a), .ss_l(ss_a)
  );
  spi_dac_wb_responder #(.SPI_WID(24), .CLK_HALF(8), .WAIT_TIMEOUT(16)) dut_b (
    .clk(clk), .rst_n(rst_n), .wb_cyc(cyc && use_b), .wb_stb(stb), .wb_we(we), .wb_sel(sel),
    .wb_adr(adr), .wb_dat_w(dw), .wb_dat_r(dr_b), .wb_ack(ack_b),
    .sck(sck_b), .mosi(mosi_b), .miso(1'b0), .ss_l(ss_b)
  );
  assign ack_m = use_b ? ack_b : ack_a;
  assign dr_m = use_b ? dr_b : dr_a;

  // SPI slave model: capture mosi on SCK fall, present the next miso bit on SCK rise.
  always @(negedge sck_a) if (rst_n && !ss_a) begin
    rx = {rx[22:0], mosi_a};
    nb++;
  end
  always @(posedge sck_a) if (mi < 24) begin
    miso_a = pat[5'(23 - mi)];
    mi++;
  end
  always @(posedge clk) if (rst_n && nb > 0 && nb < 24 && ss_a) ss_glitch = 1'b1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic xfer(input logic w, input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                      output logic [31:0] r, output int lat);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = w; adr = a; dw = d; sel = s; lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
    end while (!ack_m && lat < 2000);
    r = dr_m;
    cyc = 1'b0; stb = 1'b0; we = 1'b0;
    check("ack_seen", 32'(ack_m), 32'd1);
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
    logic [31:0] r;
    int l;
    xfer(1'b1, a, d, s, r, l);
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    logic [31:0] r;
    int l;
    xfer(1'b0, a, 32'h0, 4'hF, r, l);
    check(tag, r, exp);
  endtask

  task automatic run_frame(input logic [23:0] ts, input logic [23:0] p, input logic disarm);
    logic [31:0] r;
    int l;
    wr(32'h0C, {8'h0, ts}, 4'hF);
    m_ts = ts;
    pat = p; mi = 0; nb = 0; rx = '0; ss_glitch = 1'b0;
    wr(32'h04, 32'h1, 4'hF);
    if (disarm) wr(32'h04, 32'h0, 4'hF);
    m_arm = !disarm;
    wr(32'h0C, {8'h0, ~ts}, 4'hF);
    m_ts = ~ts;
    xfer(1'b0, 32'h10, 32'h0, 4'hF, r, l);
    check("wait_data", r, m_arm ? 32'h2 : 32'h1);
    check("wait_held", 32'(l > 48), 32'd1);
    m_from = p;
    check("mosi_bits", 32'(nb), 32'd24);
    check("mosi_value", 32'(rx), 32'(ts));
    check("ss_low_whole_frame", 32'(ss_glitch), 32'd0);
    rd_chk("finished", 32'h08, 32'(m_arm));
    rd_chk("ready", 32'h00, 32'(!m_arm));
    rd_chk("from_slave", 32'h14, 32'(m_from));
    rd_chk("to_slave", 32'h0C, 32'(m_ts));
    if (m_arm) begin
      wr(32'h04, 32'h0, 4'hF);
      m_arm = 1'b0;
    end
    rd_chk("idle_again", 32'h00, 32'h1);
  endtask

  initial begin
    logic [31:0] r, o, n, bm, exp;
    logic [3:0] s;
    int l, acks, k;
    m_ts = '0; m_from = '0; m_arm = 1'b0; rx = '0; pat = '0; ss_glitch = 1'b0;
    repeat (3) @(posedge clk);
    check("rst_ss_l", 32'(ss_a), 32'd1);
    check("rst_sck", 32'(sck_a), 32'd0);
    check("rst_mosi", 32'(mosi_a), 32'd0);
    check("rst_ack", 32'(ack_a), 32'd0);
    check("rst_dat", dr_a, 32'h0);
    #1 rst_n = 1'b1;
    rd_chk("rst_ready", 32'h00, 32'h1);
    rd_chk("rst_arm", 32'h04, 32'h0);
    rd_chk("rst_finished", 32'h08, 32'h0);
    rd_chk("rst_to_slave", 32'h0C, 32'h0);
    rd_chk("rst_from_slave", 32'h14, 32'h0);

    run_frame(24'h0ABCDE, 24'($urandom), 1'b0);
    run_frame(24'($urandom), 24'($urandom), 1'b1);
    run_frame(24'($urandom), 24'h5A5A5A, 1'b0);
    for (int i = 0; i < 4; i++) run_frame(24'($urandom), 24'($urandom), 1'($urandom));

    wr(32'h0C, 32'h123456, 4'hF);
    wr(32'h0C, 32'h0000FF00, 4'b0010);
    rd_chk("sel_merge_fixed", 32'h0C, 32'h12FF56);
    xfer(1'b1, 32'h00, 32'hFFFFFFFF, 4'hF, r, l);
    check("ro_write_lat", 32'(l), 32'd1);
    rd_chk("ro_unchanged", 32'h00, 32'h1);
    wr(32'h04, 32'h1, 4'h0);
    rd_chk("arm_sel_masked", 32'h04, 32'h0);
    wr(32'h18, 32'hFFFFFFFF, 4'hF);
    rd_chk("unmapped_18", 32'h18, 32'h0);
    rd_chk("unmapped_1c", 32'h1C, 32'h0);
    for (int i = 0; i < 4; i++) begin
      o = $urandom; n = $urandom; s = 4'($urandom);
      wr(32'h0C, o, 4'hF);
      wr(32'h0C, n, s);
      bm = {{8{s[3]}}, {8{s[2]}}, {8{s[1]}}, {8{s[0]}}};
      exp = ((n & bm) | (o & ~bm)) & 32'h00FFFFFF;
      rd_chk("sel_merge_rand", 32'h0C, exp);
    end

    use_b = 1'b1;
    wr(32'h04, 32'h1, 4'hF);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, r, l);
    check("timeout_lat", 32'(l), 32'd16);
    check("timeout_data", r, 32'h0);
    @(posedge clk); #1;
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; acks = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (ack_b) acks++;
    end
    cyc = 1'b0; stb = 1'b0;
    repeat (20) begin
      @(posedge clk); #1;
      if (ack_b) acks++;
    end
    check("abandon_no_ack", 32'(acks), 32'd0);
    xfer(1'b0, 32'h10, 32'h0, 4'hF, r, l);
    check("timeout_after_abandon", 32'(l), 32'd16);
    xfer(1'b1, 32'h10, 32'h0, 4'hF, r, l);
    check("wait_write_lat", 32'(l), 32'd1);
    use_b = 1'b0;

    wr(32'h0C, {8'h0, 24'($urandom)}, 4'hF);
    pat = 24'($urandom); mi = 0; nb = 0;
    wr(32'h04, 32'h1, 4'hF);
    k = 0;
    while (nb < 10 && k < 2000) begin
      @(posedge clk);
      k++;
    end
    check("reached_bit10", 32'(nb >= 10), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("midreset_ss_l", 32'(ss_a), 32'd1);
    check("midreset_sck", 32'(sck_a), 32'd0);
    @(posedge clk); #1 rst_n = 1'b1;
    rd_chk("midreset_ready", 32'h00, 32'h1);
    rd_chk("midreset_from", 32'h14, 32'h0);
    rd_chk("midreset_arm", 32'h04, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_dac_wb_responder.md
SPI_DAC_WB_RESPONDER -- requirements
Module: spi_dac_wb_responder

Interface
REQ-001 Parameters SHALL be: SPI_WID, default 24, SPI frame width; CLK_HALF, default 2, clk cycles per SCK half-period (min 1); WAIT_TIMEOUT, default 4095, max stall cycles on the wait register.
REQ-002 SHALL have one clock and one reset: clk, 1-bit input, rising-edge clock; rst_n, 1-bit input, asynchronous active-low reset.
REQ-003 Bus ports SHALL be: wb_cyc, input, 1, cycle; wb_stb, input, 1, strobe; wb_we, input, 1, write enable; wb_sel, input, 4, byte lanes; wb_adr, input, 32, byte address; wb_dat_w, input, 32, write data; wb_dat_r, output, 32, read data; wb_ack, output, 1, acknowledge.
REQ-004 SPI ports SHALL be: sck, output, 1, serial clock; mosi, output, 1, data out; miso, input, 1, data in; ss_l, output, 1, active-low select.

Function
REQ-005 Register decode SHALL use wb_adr[4:2] only: 0x00 ready_to_arm (RO, bit0); 0x04 arm (RW, bit0); 0x08 finished (RO, bit0); 0x0C to_slave (RW, SPI_WID bits); 0x10 wait_ready_or_finished (RO); 0x14 from_slave (RO, SPI_WID bits); other offsets read 0 and ignore writes.
REQ-006 Classic Wishbone: a request is wb_cyc&&wb_stb; wb_ack SHALL be a one-cycle pulse, asserted the cycle after the request is sampled for all offsets except 0x10, and never on two consecutive cycles.
REQ-007 Writes SHALL honour wb_sel per byte; unused upper bits SHALL read 0; writes to RO offsets SHALL be acked and discarded.
REQ-008 Reads of 0x10 SHALL stall (no ack) until ready_to_arm||finished, then ack with wb_dat_r = {30'b0, finished, ready_to_arm}.
REQ-009 If the 0x10 stall reaches WAIT_TIMEOUT cycles, wb_ack SHALL assert with wb_dat_r = 0.
REQ-010 If wb_cyc drops before ack, the pending access SHALL be abandoned with no ack and no register side effect.
REQ-011 SPI FSM states SHALL be IDLE, SHIFT, FINISHED; ready_to_arm = (state==IDLE), finished = (state==FINISHED).
REQ-012 IDLE->SHIFT when arm==1: load shift register from to_slave, ss_l<=0; a later to_slave write SHALL NOT alter the frame in flight.
REQ-013 SHIFT SHALL be SPI mode 1 (CPOL=0, CPHA=1), MSB first, SPI_WID SCK periods of 2*CLK_HALF clk each; mosi changes on SCK rise, miso sampled on SCK fall.
REQ-014 After the final bit, ss_l<=1, sck=0, from_slave<=captured bits; next state SHALL be FINISHED if arm==1, else IDLE.
REQ-015 Clearing arm during SHIFT SHALL NOT abort the frame.
REQ-016 FINISHED->IDLE SHALL occur the cycle after arm is sampled 0; re-arming requires passing through IDLE.
REQ-017 An arm write and a transfer completion in the same cycle SHALL use the new arm value for the REQ-014 decision.

Reset
REQ-018 On rst_n low, asynchronously: state=IDLE, wb_ack=0, wb_dat_r=0, sck=0, mosi=0, ss_l=1, arm=0, to_slave=0, from_slave=0, stall counter=0.
REQ-019 Reset mid-frame SHALL force ss_l high immediately; no partial from_slave update.

Structure
REQ-020 Register offsets and FSM state encodings SHALL live in a shared package reused by the bus-master side.
REQ-021 The serial engine SHALL be a sub-module spi_shift_engine (arm, to_slave, from_slave, ready_to_arm, finished, SPI pins); the bus decode/stall logic lives in the top.

Verification
REQ-022 Write 0x0C=0x0ABCDE, write 0x04=1: mosi serialises 0x0ABCDE MSB first over 24 SCK periods, ss_l low throughout, 0x08 reads 1 afterward.
REQ-023 Arm then immediately disarm (0x04=1, 0x04=0), read 0x10: ack withheld until frame ends, returns 0x1; ss_l stays low for the full 24 bits.
REQ-024 miso driving 0x5A5A5A during a frame -> 0x14 reads 0x5A5A5A after completion.
REQ-025 0x10 read with engine held in SHIFT for WAIT_TIMEOUT=16 (CLK_HALF large) -> ack on cycle 16 with data 0.
REQ-026 wb_sel=4'b0010 write of 0x0000FF00 to 0x0C holding 0x123456 -> reads 0x12FF56; write to 0x00 is acked, value unchanged.
REQ-027 rst_n pulsed low at bit 10 of a frame -> ss_l=1, sck=0 immediately; 0x00 reads 1, 0x14 reads 0 after release.
